mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit holding the architectural HI/LO registers for the MIPS core. It replaces single-cycle combinational mult/div in the execute stage with a parametrised radix-2 sequential datapath behind a start/busy/done handshake. It also services mthi/mtlo writes. The pipeline stalls on `busy` before reading HI/LO (mfhi/mflo).

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x ignored.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / mthi/mtlo source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  iteration in progress.
- `done`  out  1  one-cycle pulse: HI/LO updated by a mult/div.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

One clock; reset is synchronous and active-low.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: `start`=1 with a mult/div op → latch magnitudes of `a`/`b` (signed ops take |x|, unsigned ops pass through), latch the result signs, load counter = WIDTH, go to RUN. `a`/`b` are not needed after the start cycle.
- mthi/mtlo in IDLE: `hi`/`lo` ← `a` at that edge. FSM stays IDLE; no `busy`, no `done`.
- Ignored in IDLE, with no state change: undefined ops (11x), and div/divu when the macro is absent.
- RUN, multiply: shift-add over a 2·WIDTH-bit accumulator, one multiplier bit per cycle.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle.
- RUN: counter decrements each cycle; reaching 0 moves to FIX.
- FIX, mult: negate the 2·WIDTH product if the operand signs differ.
- FIX, div: negate the quotient if the signs differ; give the remainder the dividend's sign (truncation toward zero).
- FIX: write `hi` ← product[2W-1:W] or remainder, `lo` ← product[W-1:0] or quotient. Go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` in DONE is ignored.
- Divide by zero: no trap. `lo` = all-ones, `hi` = `a` as presented, sign fixup skipped, same latency as a normal divide.
- Signed overflow (MIN / −1): `lo` = MIN, `hi` = 0. No flag.
- `start` while `busy`: ignored, not queued. The core must hold the request.
- `rst_n`=0 at any edge, including mid-RUN/FIX: FSM → IDLE, operation discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Start sampled at the end of cycle 0.
- `busy`=1 in cycles 1 .. WIDTH+1: WIDTH RUN cycles plus one FIX cycle.
- `hi`/`lo` update at the end of cycle WIDTH+1.
- `done`=1, `busy`=0 in cycle WIDTH+2.
- A new start is accepted from the end of cycle WIDTH+3. WIDTH=32: latency 34 cycles, issue interval 35.
- mthi/mtlo: `hi`/`lo` visible the cycle after the start cycle.
- `hi`/`lo` hold their old value throughout `busy`. They are never partially updated.
- `busy` and `done` are registered outputs, with no combinational path from `start`.

## Configuration
- `MDU_DIV_EN` defined: div/divu implemented as above.
- `MDU_DIV_EN` undefined:
  - the divide datapath (subtractor, remainder register, div fixup) is compiled out;
  - div/divu starts are ignored like undefined ops: no `busy`, no `done`, HI/LO unchanged;
  - mult/multu/mthi/mtlo are unaffected.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → `busy`=0, `done`=0, `hi`=`lo`=0.
- mult/multu, WIDTH=32, a=0x86E1FB43, b=0x6B72C901:
  - mult → `done` in cycle 34, `hi`=0xCD2A258D, `lo`=0xD9FF9643;
  - multu → `hi`=0x389CEE8E, same `lo`.
- div/divu, a=0x8396A10C, b=0x02A13C92:
  - div → `lo`=0xFFFFFFD1, `hi`=0xFF30BFDA;
  - divu → `lo`=0x00000032, `hi`=0x0018CC88.
- Boundary divides:
  - divu a=0x12345678, b=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678;
  - div a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Handshake: mthi a=0x7B93A612 → `hi`=0x7B93A612 next cycle, no `done`. Then mult; `start` pulses mid-RUN → ignored, single `done`, result unchanged.
- Reset mid-operation: deassert `rst_n` in cycle 10 of a divu → next cycle `busy`=0, `hi`=`lo`=0, no `done` ever. A following mult completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the execute stage and mult_div_unit
//
// Purpose: groups the multiply/divide handshake and the HI/LO read-out.
// Signals:
//   start  request strobe, sampled by the unit only while busy=0
//   op     3-bit operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   a      rs operand (dividend / multiplicand / mthi-mtlo source)
//   b      rt operand (divisor / multiplier)
//   busy   iteration in progress
//   done   one-cycle pulse after HI/LO were written by a mult/div
//   hi     HI register
//   lo     LO register
// Modports: master = pipeline side, slave = unit side.

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit holding HI/LO
//
// Purpose: sequential shift-add multiplier and restoring divider behind a
// start/busy/done handshake, plus mthi/mtlo writes. One result bit per cycle,
// WIDTH iteration cycles followed by one sign-fixup cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mult_div_unit_if.slave: start/op/a/b in, busy/done/hi/lo out
// Build option: define MDU_DIV_EN to implement div/divu. Without it the
// divide datapath is absent and div/divu requests are ignored.

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, next_state;

  logic [CW-1:0]        cnt;
  // mult: {partial product, remaining multiplier bits}
  // div:  {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;      // |multiplicand| or |divisor|
  logic                 neg_q;     // product / quotient must be negated
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef MDU_DIV_EN
  logic                 is_div;
  logic                 neg_r;     // remainder takes the dividend's sign
  logic                 div_zero;
  logic [WIDTH-1:0]     a_raw;     // dividend as presented, for divide-by-zero
`endif

  // Request decode and operand magnitudes
  logic             op_mul;
  logic             op_div;
  logic             op_signed;
  logic             accept;
  logic             wr_hi;
  logic             wr_lo;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    op_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MDU_DIV_EN
    op_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`else
    op_div = 1'b0;
`endif
    // op[0]=0 selects the signed flavour of both mult and div
    op_signed = ~bus.op[0];
    sign_a    = op_signed & bus.a[WIDTH-1];
    sign_b    = op_signed & bus.b[WIDTH-1];
    abs_a     = sign_a ? -bus.a : bus.a;
    abs_b     = sign_b ? -bus.b : bus.b;
    accept    = (state == IDLE) && bus.start && (op_mul || op_div);
    wr_hi     = (state == IDLE) && bus.start && (bus.op == OP_MTHI);
    wr_lo     = (state == IDLE) && bus.start && (bus.op == OP_MTLO);
  end

  // One iteration step
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   step_acc;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
`endif

  always_comb begin
    // add multiplicand when the current multiplier bit is set, then shift right
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    step_acc = {mul_sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    // shift next dividend bit into remainder; keep the difference if no borrow
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_trial[WIDTH]) begin
        step_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        step_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  // Sign fixup and result selection
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod   = neg_q ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        // MIN / -1 falls out naturally: |MIN| / 1 = MIN, signs agree, rem 0
        fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (cnt == CW'(1)) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
`endif
    end else begin
      busy_q <= (next_state == RUN) || (next_state == FIX);
      done_q <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CW'(WIDTH);
            neg_q <= sign_a ^ sign_b;
            if (op_mul) begin
              opnd <= abs_a;
              acc  <= {{WIDTH{1'b0}}, abs_b};
            end else begin
              opnd <= abs_b;
              acc  <= {{WIDTH{1'b0}}, abs_a};
            end
`ifdef MDU_DIV_EN
            is_div   <= op_div;
            neg_r    <= sign_a;
            div_zero <= (bus.b == '0);
            a_raw    <= bus.a;
`endif
          end else if (wr_hi) begin
            hi_q <= bus.a;
          end else if (wr_lo) begin
            lo_q <= bus.a;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          acc <= step_acc;
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
